// File: rtl/program_loader.sv
// Instruction-memory writer: assembles a length-prefixed byte stream into 32-bit words
// and writes them at consecutive word addresses while holding the core stalled.
module program_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_LAST,
      S_DONE,
      S_ERR
   } state_t;

   // Number of words that fit between BASE_ADDR and the top of memory.
   localparam logic [16:0]       MAX_WORDS = 17'((1 << ADDR_W) - BASE_ADDR);
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

   state_t              state_q, state_d;
   logic [15:0]         count_q, count_d;
   logic [1:0]          idx_q, idx_d;
   logic [31:0]         asm_q, asm_d;
   logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                accept;
   logic [15:0]         len_full;
   logic [31:0]         word_full;

   assign in_ready   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
   assign busy       = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                       (state_q == S_DATA)   || (state_q == S_LAST);
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERR);
   assign core_hold  = (state_q != S_DONE);
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;

   assign accept    = in_valid && in_ready;
   assign len_full  = {count_q[15:8], in_data};
   assign word_full = {asm_q[23:0], in_data};

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      idx_d      = idx_q;
      asm_d      = asm_q;
      addr_cnt_d = addr_cnt_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_LEN_HI;
               addr_cnt_d = BASE;
               count_d    = 16'd0;
               idx_d      = 2'd0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               count_d = {in_data, count_q[7:0]};
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               count_d = len_full;
               idx_d   = 2'd0;
               if (len_full == 16'd0) begin
                  state_d = S_DONE;
               end else if ({1'b0, len_full} > MAX_WORDS) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               asm_d = word_full;
               idx_d = idx_q + 2'd1;
               // Fourth byte: register the write so it appears on the following cycle.
               if (idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  addr_d     = addr_cnt_q;
                  wdata_d    = word_full;
                  addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                  count_d    = count_q - 16'd1;
                  if (count_q == 16'd1) begin
                     state_d = S_LAST;
                  end
               end
            end
         end
         S_LAST: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         count_q    <= 16'd0;
         idx_q      <= 2'd0;
         asm_q      <= 32'd0;
         addr_cnt_q <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         asm_q      <= asm_d;
         addr_cnt_q <= addr_cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

endmodule
